// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: instruction types, FSM states,
// trap causes, writeback source codes and small decode helpers.
package core_sequencer_pkg;

    localparam int INSTR_TYPE_WIDTH = 4;

    typedef enum logic [INSTR_TYPE_WIDTH-1:0] {
        IT_ALU_R  = 4'd0,
        IT_ALU_I  = 4'd1,
        IT_LOAD   = 4'd2,
        IT_STORE  = 4'd3,
        IT_BRANCH = 4'd4,
        IT_JUMP   = 4'd5,
        IT_LUI    = 4'd6,
        IT_AUIPC  = 4'd7,
        IT_ENV    = 4'd8
    } instr_type_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_ILLEGAL      = 2'd0;
    localparam logic [1:0] CAUSE_IMEM_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGNED   = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    function automatic logic writes_rd(instr_type_t t);
        case (t)
            IT_ALU_R, IT_ALU_I, IT_LOAD, IT_JUMP, IT_LUI, IT_AUIPC: writes_rd = 1'b1;
            default:                                               writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] wb_source(instr_type_t t);
        case (t)
            IT_LOAD: wb_source = WB_MEM;
            IT_JUMP: wb_source = WB_PC4;
            IT_LUI:  wb_source = WB_IMM;
            default: wb_source = WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer and memory.
interface core_sequencer_if;
    // A request stays high, with its address and direction stable, until ack is
    // sampled high on a rising edge; that edge completes the transfer. Ack seen
    // while the matching request is low carries no meaning and is ignored.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/core_sequencer_wait_timer.sv
// Counts cycles an outstanding memory request has gone unanswered and flags
// the cycle in which the count would reach LIMIT.
module wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Only a cycle without ack counts, so an ack on the final cycle still wins.
    assign expired = enable && (count == 8'(LIMIT - 1));
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory access and
// writeback with timeout and misaligned-target traps.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    core_sequencer_if.master            mem,
    output logic [31:0]                 ir,
    input  logic                        dec_valid,
    input  logic [INSTR_TYPE_WIDTH-1:0] dec_instr_type,
    input  logic                        dec_rd_enable,
    input  logic                        branch_taken,
    input  logic [31:0]                 target_addr,
    output logic                        rf_we,
    output logic [1:0]                  wb_sel,
    output logic [31:0]                 pc,
    output logic                        retire,
    output logic [31:0]                 instret,
    output logic                        halted,
    output logic                        trap,
    output logic [1:0]                  trap_cause,
    output state_t                      state
);
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    instr_type_t itype;
    logic        rd_enable;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;

    assign mem.imem_req  = imem_req;
    assign mem.imem_addr = pc;
    assign mem.dmem_req  = dmem_req;
    assign mem.dmem_we   = dmem_we;

    assign redirect    = (itype == IT_JUMP) || ((itype == IT_BRANCH) && branch_taken);
    assign redirect_pc = target_addr & ~32'd1;

    // Any cycle with no request outstanding rearms the timer for the next one.
    assign timer_clear  = !(imem_req || dmem_req);
    assign timer_enable = (imem_req && !mem.imem_ack) || (dmem_req && !mem.dmem_ack);

    wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= 32'd0;
            instret    <= 32'd0;
            trap_cause <= CAUSE_ILLEGAL;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            retire     <= 1'b0;
            wb_sel     <= WB_ALU;
            halted     <= 1'b0;
            trap       <= 1'b0;
            itype      <= IT_ALU_R;
            rd_enable  <= 1'b0;
            next_pc    <= RESET_PC;
        end else begin
            case (state)
                ST_FETCH: begin
                    // Coming out of reset the request is not yet raised; raise it first.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (mem.imem_ack) begin
                        ir       <= mem.imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (timer_expired) begin
                        imem_req   <= 1'b0;
                        trap_cause <= CAUSE_IMEM_TIMEOUT;
                        halted     <= 1'b1;
                        trap       <= 1'b1;
                        state      <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    itype     <= instr_type_t'(dec_instr_type);
                    rd_enable <= dec_rd_enable;
                    if (!dec_valid) begin
                        trap_cause <= CAUSE_ILLEGAL;
                        halted     <= 1'b1;
                        trap       <= 1'b1;
                        state      <= ST_TRAP;
                    end else if (dec_instr_type == IT_ENV) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if ((itype == IT_LOAD) || (itype == IT_STORE)) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (itype == IT_STORE);
                        state    <= ST_MEM;
                    end else if (redirect && redirect_pc[1]) begin
                        trap_cause <= CAUSE_MISALIGNED;
                        halted     <= 1'b1;
                        trap       <= 1'b1;
                        state      <= ST_TRAP;
                    end else begin
                        next_pc <= redirect ? redirect_pc : pc + 32'd4;
                        rf_we   <= rd_enable && writes_rd(itype);
                        wb_sel  <= wb_source(itype);
                        retire  <= 1'b1;
                        state   <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (mem.dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        next_pc  <= pc + 32'd4;
                        rf_we    <= rd_enable && writes_rd(itype);
                        wb_sel   <= wb_source(itype);
                        retire   <= 1'b1;
                        state    <= ST_WRITEBACK;
                    end else if (timer_expired) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        trap_cause <= CAUSE_DMEM_TIMEOUT;
                        halted     <= 1'b1;
                        trap       <= 1'b1;
                        state      <= ST_TRAP;
                    end
                end
                ST_WRITEBACK: begin
                    pc       <= next_pc;
                    instret  <= instret + 32'd1;
                    rf_we    <= 1'b0;
                    retire   <= 1'b0;
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALT, ST_TRAP: begin
                    state <= state;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a table of single-instruction vectors plus
// hand-written sequences for chaining and reset during a memory wait.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_sequencer_if mem ();

    logic [31:0]                 ir;
    logic                        dec_valid;
    logic [INSTR_TYPE_WIDTH-1:0] dec_instr_type;
    logic                        dec_rd_enable;
    logic                        branch_taken;
    logic [31:0]                 target_addr;
    logic                        rf_we;
    logic [1:0]                  wb_sel;
    logic [31:0]                 pc;
    logic                        retire;
    logic [31:0]                 instret;
    logic                        halted;
    logic                        trap;
    logic [1:0]                  trap_cause;
    state_t                      state;

    int checks = 0;
    int errors = 0;

    core_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem            (mem),
        .ir             (ir),
        .dec_valid      (dec_valid),
        .dec_instr_type (dec_instr_type),
        .dec_rd_enable  (dec_rd_enable),
        .branch_taken   (branch_taken),
        .target_addr    (target_addr),
        .rf_we          (rf_we),
        .wb_sel         (wb_sel),
        .pc             (pc),
        .retire         (retire),
        .instret        (instret),
        .halted         (halted),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .state          (state)
    );

    typedef struct {
        logic [3:0]  itype;
        logic        valid;
        logic        rd_en;
        logic        taken;
        logic [31:0] target;
        int          imem_wait;
        int          dmem_wait;
        int          exp_cycle;
        logic        exp_halt;
        logic        exp_rf;
        logic [1:0]  exp_wb;
        logic [31:0] exp_pc;
        logic [31:0] exp_instret;
        logic        exp_trap;
        logic [1:0]  exp_cause;
        logic        exp_we;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [3:0] t, logic valid, logic rd_en, logic taken,
                                logic [31:0] tgt, int iw, int dw, int cyc, logic halt,
                                logic rf, logic [1:0] wb, logic [31:0] pc_e,
                                logic [31:0] inst, logic trap_e, logic [1:0] cause,
                                logic we);
        vec_t v;
        v.itype = t; v.valid = valid; v.rd_en = rd_en; v.taken = taken; v.target = tgt;
        v.imem_wait = iw; v.dmem_wait = dw; v.exp_cycle = cyc; v.exp_halt = halt;
        v.exp_rf = rf; v.exp_wb = wb; v.exp_pc = pc_e; v.exp_instret = inst;
        v.exp_trap = trap_e; v.exp_cause = cause; v.exp_we = we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem.imem_ack = 1'b0;
        mem.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one instruction from its first request cycle (cycle 1) until it
    // retires or the core stops; acks seen while no request is up are stray.
    task automatic run_instr(input vec_t v, input logic [31:0] exp_addr,
                             input logic [31:0] rdata, input string tag);
        int n = 0, ireq = 0, dreq = 0, ret_cnt = 0, ret_cyc = 0, rf_cnt = 0;
        int halt_cyc = 0, addr_bad = 0, idle_bad = 0;
        logic [1:0] wb_ret = 2'd0;
        logic we_seen = 1'b0;
        bit done = 1'b0;
        state_t st;
        dec_valid = v.valid;
        dec_instr_type = v.itype;
        dec_rd_enable = v.rd_en;
        branch_taken = v.taken;
        target_addr = v.target;
        mem.imem_rdata = rdata;
        for (int k = 0; k < 8 && !mem.imem_req; k++) @(negedge clk);
        check({tag, ".req_start"}, 32'(mem.imem_req), 32'd1);
        while (!done && n < 40) begin
            n++;
            if (retire) begin ret_cnt++; ret_cyc = n; wb_ret = wb_sel; end
            if (rf_we) rf_cnt++;
            if (mem.dmem_req && mem.dmem_we) we_seen = 1'b1;
            if (mem.imem_req && ret_cnt == 0 && mem.imem_addr !== exp_addr) addr_bad++;
            if (halted) begin halt_cyc = n; done = 1'b1; end
            else if (ret_cnt > 0 && !retire) done = 1'b1;
            if (done) begin
                mem.imem_ack = 1'b0;
                mem.dmem_ack = 1'b0;
            end else begin
                if (mem.imem_req) begin mem.imem_ack = (ireq == v.imem_wait); ireq++; end
                else mem.imem_ack = 1'b1;
                if (mem.dmem_req) begin mem.dmem_ack = (dreq == v.dmem_wait); dreq++; end
                else mem.dmem_ack = 1'b1;
                @(negedge clk);
            end
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".cycle"}, 32'(v.exp_halt ? halt_cyc : ret_cyc), 32'(v.exp_cycle));
        check({tag, ".retires"}, 32'(ret_cnt), v.exp_halt ? 32'd0 : 32'd1);
        check({tag, ".rf_we"}, 32'(rf_cnt), 32'(v.exp_rf));
        if (ret_cnt > 0) check({tag, ".wb_sel"}, 32'(wb_ret), 32'(v.exp_wb));
        check({tag, ".pc"}, pc, v.exp_pc);
        check({tag, ".instret"}, instret, v.exp_instret);
        check({tag, ".halted"}, 32'(halted), 32'(v.exp_halt));
        check({tag, ".trap"}, 32'(trap), 32'(v.exp_trap));
        check({tag, ".trap_cause"}, 32'(trap_cause), 32'(v.exp_cause));
        check({tag, ".dmem_we"}, 32'(we_seen), 32'(v.exp_we));
        check({tag, ".imem_addr"}, 32'(addr_bad), 32'd0);
        check({tag, ".ir"}, ir, (v.imem_wait < 8) ? rdata : 32'd0);
        if (halted) begin
            st = state;
            repeat (4) begin
                mem.imem_ack = 1'b1;
                mem.dmem_ack = 1'b1;
                @(negedge clk);
                if (mem.imem_req || mem.dmem_req || state != st || !halted) idle_bad++;
            end
            mem.imem_ack = 1'b0;
            mem.dmem_ack = 1'b0;
            check({tag, ".stopped"}, 32'(idle_bad), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        mem.imem_ack = 1'b0;
        mem.dmem_ack = 1'b0;
        mem.imem_rdata = 32'd0;
        dec_valid = 1'b0;
        dec_instr_type = '0;
        dec_rd_enable = 1'b0;
        branch_taken = 1'b0;
        target_addr = 32'd0;

        //        type       vld rd tk target        iw   dw   cyc hlt rf wb      pc        inst tr cause               we
        vecs[0]  = mk(IT_ALU_R,  1, 1, 0, 32'h0,       0,   0,   4, 0, 1, WB_ALU, 32'h4,    1, 0, 2'd0,               0);
        vecs[1]  = mk(IT_ALU_I,  1, 0, 0, 32'h0,       0,   0,   4, 0, 0, WB_ALU, 32'h4,    1, 0, 2'd0,               0);
        vecs[2]  = mk(IT_BRANCH, 1, 1, 1, 32'h40,      0,   0,   4, 0, 0, WB_ALU, 32'h40,   1, 0, 2'd0,               0);
        vecs[3]  = mk(IT_BRANCH, 1, 1, 0, 32'h40,      0,   0,   4, 0, 0, WB_ALU, 32'h4,    1, 0, 2'd0,               0);
        vecs[4]  = mk(IT_JUMP,   1, 1, 0, 32'h81,      0,   0,   4, 0, 1, WB_PC4, 32'h80,   1, 0, 2'd0,               0);
        vecs[5]  = mk(IT_JUMP,   1, 1, 0, 32'h82,      0,   0,   4, 1, 0, WB_ALU, 32'h0,    0, 1, CAUSE_MISALIGNED,   0);
        vecs[6]  = mk(IT_LOAD,   1, 1, 0, 32'h0,       0,   3,   8, 0, 1, WB_MEM, 32'h4,    1, 0, 2'd0,               0);
        vecs[7]  = mk(IT_STORE,  1, 1, 0, 32'h0,       0,   0,   5, 0, 0, WB_ALU, 32'h4,    1, 0, 2'd0,               1);
        vecs[8]  = mk(IT_LUI,    1, 1, 0, 32'h0,       2,   0,   6, 0, 1, WB_IMM, 32'h4,    1, 0, 2'd0,               0);
        vecs[9]  = mk(IT_AUIPC,  1, 1, 0, 32'h0,       0,   0,   4, 0, 1, WB_ALU, 32'h4,    1, 0, 2'd0,               0);
        vecs[10] = mk(IT_ENV,    1, 0, 0, 32'h0,       0,   0,   3, 1, 0, WB_ALU, 32'h0,    0, 0, 2'd0,               0);
        vecs[11] = mk(IT_ALU_R,  0, 1, 0, 32'h0,       0,   0,   3, 1, 0, WB_ALU, 32'h0,    0, 1, CAUSE_ILLEGAL,      0);
        vecs[12] = mk(IT_ALU_R,  1, 1, 0, 32'h0,       255, 0,   9, 1, 0, WB_ALU, 32'h0,    0, 1, CAUSE_IMEM_TIMEOUT, 0);
        vecs[13] = mk(IT_ALU_R,  1, 1, 0, 32'h0,       7,   0,  11, 0, 1, WB_ALU, 32'h4,    1, 0, 2'd0,               0);
        vecs[14] = mk(IT_LOAD,   1, 1, 0, 32'h0,       0,   255,12, 1, 0, WB_ALU, 32'h0,    0, 1, CAUSE_DMEM_TIMEOUT, 0);
        vecs[15] = mk(IT_STORE,  1, 1, 0, 32'h0,       0,   7,  12, 0, 0, WB_ALU, 32'h4,    1, 0, 2'd0,               1);
        vecs[16] = mk(IT_BRANCH, 1, 0, 1, 32'h42,      0,   0,   4, 1, 0, WB_ALU, 32'h0,    0, 1, CAUSE_MISALIGNED,   0);

        // Values held while reset is asserted.
        @(negedge clk);
        check("reset.pc", pc, 32'h0);
        check("reset.ir", ir, 32'h0);
        check("reset.instret", instret, 32'h0);
        check("reset.trap_cause", 32'(trap_cause), 32'd0);
        check("reset.strobes", 32'({mem.imem_req, mem.dmem_req, mem.dmem_we, rf_we, retire,
                                    halted, trap}), 32'd0);
        check("reset.wb_sel", 32'(wb_sel), 32'd0);
        check("reset.state", 32'(state), 32'(ST_FETCH));

        for (int i = 0; i < 17; i++) begin
            do_reset();
            run_instr(vecs[i], 32'h0, 32'hC0DE_0000 + 32'(i), $sformatf("vec%0d", i));
        end

        // Three instructions back to back: sequential, redirect with bit 0 dropped, sequential.
        do_reset();
        v = mk(IT_ALU_R, 1, 1, 0, 32'h0, 0, 0, 4, 0, 1, WB_ALU, 32'h4, 1, 0, 2'd0, 0);
        run_instr(v, 32'h0, 32'h1111_0000, "chain0");
        v = mk(IT_BRANCH, 1, 0, 1, 32'h41, 0, 0, 4, 0, 0, WB_ALU, 32'h40, 2, 0, 2'd0, 0);
        run_instr(v, 32'h4, 32'h1111_0001, "chain1");
        v = mk(IT_LUI, 1, 1, 0, 32'h0, 0, 0, 4, 0, 1, WB_IMM, 32'h44, 3, 0, 2'd0, 0);
        run_instr(v, 32'h40, 32'h1111_0002, "chain2");

        // Reset in the middle of a data-memory wait, then in the middle of a fetch wait.
        do_reset();
        v = mk(IT_ALU_R, 1, 1, 0, 32'h0, 0, 0, 4, 0, 1, WB_ALU, 32'h4, 1, 0, 2'd0, 0);
        run_instr(v, 32'h0, 32'h2222_0000, "rst_pre");
        dec_instr_type = IT_LOAD;
        for (int k = 0; k < 10 && !mem.dmem_req; k++) begin
            mem.imem_ack = mem.imem_req;
            @(negedge clk);
        end
        mem.imem_ack = 1'b0;
        mem.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem.req_before", 32'(mem.dmem_req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mem.dmem_req", 32'(mem.dmem_req), 32'd0);
        check("rst_mem.pc", pc, 32'h0);
        check("rst_mem.instret", instret, 32'h0);
        check("rst_mem.ir", ir, 32'h0);
        check("rst_mem.state", 32'(state), 32'(ST_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem.refetch_req", 32'(mem.imem_req), 32'd1);
        check("rst_mem.refetch_addr", mem.imem_addr, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_fetch.req_before", 32'(mem.imem_req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_fetch.imem_req", 32'(mem.imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for a memory ack before trap (range 1..255).
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- imem_req, out, 1, instruction fetch request.
- imem_addr, out, 32, fetch address.
- imem_ack, in, 1, fetch complete.
- imem_rdata, in, 32, fetched word.
- ir, out, 32, latched instruction driven to the decoder.
- dec_valid, in, 1, decoder valid.
- dec_instr_type, in, INSTR_TYPE_WIDTH, decoded type (shared instruction-type header).
- dec_rd_enable, in, 1, instruction writes rd.
- branch_taken, in, 1, branch condition from ALU.
- target_addr, in, 32, jump/branch target from datapath.
- dmem_req, out, 1, data request.
- dmem_we, out, 1, 1 = store.
- dmem_ack, in, 1, data complete.
- rf_we, out, 1, register-file write strobe.
- wb_sel, out, 2, writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM.
- pc, out, 32, current PC.
- retire, out, 1, one-cycle pulse per retired instruction.
- instret, out, 32, retired-instruction count.
- halted, out, 1, core stopped.
- trap, out, 1, stopped due to fault.
- trap_cause, out, 2, 0 illegal, 1 imem timeout, 2 dmem timeout, 3 misaligned target.

Function
REQ-004 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
REQ-005 FETCH: imem_req=1, imem_addr=pc, both stable until the cycle imem_ack=1; on ack latch ir<=imem_rdata, go to DECODE.
REQ-006 DECODE: one cycle; if dec_valid=0 go to TRAP with cause 0; if type ENV go to HALT; otherwise go to EXECUTE.
REQ-007 EXECUTE: one cycle; LOAD/STORE go to MEM; all other types go to WRITEBACK.
REQ-008 MEM: dmem_req=1, dmem_we=1 for STORE else 0, held until dmem_ack; then go to WRITEBACK.
REQ-009 WRITEBACK: one cycle; rf_we=dec_rd_enable for ALU_R, ALU_I, LOAD, JUMP, LUI, AUIPC, else 0; wb_sel = MEM for LOAD, PC+4 for JUMP, IMM for LUI, ALU otherwise; retire=1; instret+=1 (wraps 32'hFFFF_FFFF to 0); go to FETCH.
REQ-010 PC update in WRITEBACK: JUMP, or BRANCH with branch_taken=1, gives pc <= {target_addr[31:1],1'b0}; otherwise pc <= pc+4 (mod 2^32).
REQ-011 If the redirect value has bit 1 set, SHALL go to TRAP with cause 3, leave pc unchanged, and assert neither rf_we nor retire.
REQ-012 Zero-wait latency: non-memory instruction 4 cycles, load/store 5 cycles; each ack wait cycle adds one.
REQ-013 Timeout: wait counter clears on FETCH/MEM entry and increments each cycle without ack; reaching TIMEOUT goes to TRAP, cause 1 (FETCH) or 2 (MEM), dropping req.
REQ-014 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL be accepted; no trap.
REQ-015 imem_ack/dmem_ack outside the matching request state SHALL be ignored.
REQ-016 HALT: halted=1, trap=0. TRAP: halted=1, trap=1. No requests in either state; exit only by reset.
REQ-017 rf_we, retire, imem_req and dmem_req SHALL be 0 in every state not named above for them.

Reset
REQ-018 While rst_n=0, all outputs SHALL immediately take reset values: pc=RESET_PC, ir=0, instret=0, trap_cause=0, all strobes/flags 0, state FETCH.
REQ-019 Reset asserted mid-transaction SHALL drop imem_req/dmem_req asynchronously. After release, the first rising edge SHALL begin a FETCH at RESET_PC.

Structure
REQ-020 State encodings, trap-cause codes and wb_sel codes SHALL live in a shared header beside the instruction-type and ALU headers.
REQ-021 The wait counter SHALL be a sub-module wait_timer (clear, enable, expired).

Verification
REQ-022 ADD at RESET_PC=0, zero-wait ack: rf_we and retire high in cycle 4, wb_sel=0; then pc=4 and instret=1.
REQ-023 Taken BEQ with target_addr=0x40: pc=0x40, rf_we never high, retire pulses once.
REQ-024 LOAD with dmem_ack 3 cycles after dmem_req rises: dmem_we=0 throughout; rf_we with wb_sel=1 in cycle 8.
REQ-025 dec_valid=0: trap=1, trap_cause=0, halted=1, no further imem_req. ECALL: halted=1, trap=0.
REQ-026 TIMEOUT=8, imem_ack held 0: trap_cause=1 after 8 wait cycles. Repeat with ack on cycle 8: no trap.
REQ-027 rst_n pulsed low during MEM wait: dmem_req falls within the same cycle; next fetch at RESET_PC; instret=0.
